// File: rtl/pri_arb_8.sv
// ---------------------------------------------------------------------------
// pri_arb_8 -- eight-requester arbiter for one shared downstream resource.
//
// A winner is picked either by fixed priority (bit 7 highest, bit 0 lowest)
// or by descending round-robin starting below the last winner. The owner keeps
// the grant until it drops its request or until MAX_HOLD consecutive grant
// cycles have elapsed. A forced release pulses `timeout` and masks the owner
// out of the next arbitration. Every owner change passes through one GAP
// cycle and one IDLE arbitration cycle.
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst      in   1  synchronous active-high reset
//   en       in   1  arbitration enable (gates new grants only)
//   rr_mode  in   1  0 = fixed priority, 1 = round-robin (sampled at arbitration)
//   req      in   8  request vector, req[i] high = requester i wants/holds
//   gnt      out  8  registered one-hot grant
//   gnt_id   out  3  registered index of the owner (0 while no grant)
//   gnt_vld  out  1  high while a grant is active (|gnt)
//   timeout  out  1  one-cycle pulse in the first GAP cycle after a forced release
//   busy     out  1  high in GRANT or GAP
// ---------------------------------------------------------------------------
module pri_arb_8 #(
  parameter int unsigned MAX_HOLD = 16  // 0 disables the timeout, legal 0..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rr_mode,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // hold_cnt value seen in the last allowed grant cycle; hold_cnt is 0 in the
  // first grant cycle, so matching MAX_HOLD-1 gives exactly MAX_HOLD cycles.
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [7:0] r_gnt;
  logic [2:0] r_gnt_id;
  logic       r_timeout;
  logic [7:0] r_hold_cnt;
  logic [2:0] r_last_id;
  logic [7:0] r_mask;

  state_t     w_state_nxt;
  logic [7:0] w_gnt_nxt;
  logic [2:0] w_gnt_id_nxt;
  logic       w_timeout_nxt;
  logic [7:0] w_hold_nxt;
  logic [2:0] w_last_nxt;
  logic [7:0] w_mask_nxt;

  logic [7:0] w_elig;
  logic [2:0] w_fp_id;
  logic [2:0] w_rr_id;
  logic [2:0] w_rr_idx;
  logic [2:0] w_win_id;
  logic       w_hold_hit;

  assign w_elig     = req & ~r_mask;
  assign w_hold_hit = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);

  // Winner search. Later loop iterations overwrite earlier ones, so iterating
  // from the lowest-precedence candidate upward leaves the true winner.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise a path that skips the assignment infers a latch.
    w_fp_id  = 3'd0;
    w_rr_id  = 3'd0;
    w_rr_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_elig[i]) w_fp_id = 3'(i);
    end
    // Round-robin order is last-1, last-2, ... wrapping to last itself (s = 8),
    // so walk s from 8 down to 1 and let the nearest candidate win.
    for (int s = 8; s >= 1; s--) begin
      w_rr_idx = r_last_id - 3'(s);
      if (w_elig[w_rr_idx]) w_rr_id = w_rr_idx;
    end
    w_win_id = rr_mode ? w_rr_id : w_fp_id;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_timeout_nxt = 1'b0;
    w_hold_nxt    = r_hold_cnt;
    w_last_nxt    = r_last_id;
    // A mask bit also dies as soon as its request drops.
    w_mask_nxt    = r_mask & req;

    unique case (r_state)
      S_IDLE: begin
        if (en && (w_elig != 8'd0)) begin
          w_state_nxt  = S_GRANT;
          w_gnt_nxt    = 8'd1 << w_win_id;
          w_gnt_id_nxt = w_win_id;
          w_last_nxt   = w_win_id;
          w_mask_nxt   = 8'd0;
          w_hold_nxt   = 8'd0;
        end
      end

      S_GRANT: begin
        if (!req[r_gnt_id]) begin
          // Voluntary release wins over a coincident timeout.
          w_state_nxt  = S_GAP;
          w_gnt_nxt    = 8'd0;
          w_gnt_id_nxt = 3'd0;
        end else if (w_hold_hit) begin
          w_state_nxt   = S_GAP;
          w_gnt_nxt     = 8'd0;
          w_gnt_id_nxt  = 3'd0;
          w_timeout_nxt = 1'b1;
          w_mask_nxt    = (r_mask & req) | r_gnt;
        end else begin
          w_hold_nxt = (r_hold_cnt == 8'hFF) ? r_hold_cnt : r_hold_cnt + 8'd1;
        end
      end

      S_GAP: begin
        w_state_nxt = S_IDLE;
        w_hold_nxt  = 8'd0;
      end

      default: begin
        w_state_nxt  = S_IDLE;
        w_gnt_nxt    = 8'd0;
        w_gnt_id_nxt = 3'd0;
        w_hold_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_state    <= S_IDLE;
      r_gnt      <= 8'd0;
      r_gnt_id   <= 3'd0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= 8'd0;
      r_last_id  <= 3'd0;
      r_mask     <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_timeout  <= w_timeout_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_last_id  <= w_last_nxt;
      r_mask     <= w_mask_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = |r_gnt;
  assign timeout = r_timeout;
  assign busy    = (r_state != S_IDLE);

  // Structural invariants.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(gnt));
  a_gnt_vld : assert property (@(posedge clk) disable iff (rst)
    gnt_vld == (|gnt));
  a_gnt_only_in_grant : assert property (@(posedge clk) disable iff (rst)
    (r_state == S_GRANT) || (gnt == 8'd0));
  a_gnt_id_stable : assert property (@(posedge clk) disable iff (rst)
    (r_state == S_GRANT && $past(r_state) == S_GRANT) |-> $stable(gnt_id));

endmodule

// File: doc/pri_arb_8.md
Name: pri_arb_8

Overview:
Eight-requester arbiter that shares one downstream resource (bus slot, encoder-fed datapath) between requesters.
- Selects a winner using the codebase's priority convention: bit 7 highest, bit 0 lowest.
- Alternatively selects a winner by descending round-robin.
- Holds the grant until the owner releases it or a hold timeout fires.
- Registered one-hot grant plus 3-bit grant index; sits between request sources and the shared-resource mux.

Parameters:
MAX_HOLD, 16, maximum consecutive GRANT cycles per owner before forced release; 0 disables the timeout; legal range 0..255.

Ports:
clk      input   1  clock, all logic on rising edge
rst      input   1  synchronous active-high reset
en       input   1  arbitration enable; gates new grants only
rr_mode  input   1  0 = fixed priority, 1 = round-robin; sampled only at arbitration
req      input   8  request vector; req[i] high = requester i wants or holds resource
gnt      output  8  one-hot grant, registered
gnt_id   output  3  index of granted requester, registered
gnt_vld  output  1  high while any grant is active (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is force-released
busy     output  1  high in GRANT or GAP state

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). rst sampled high at a rising edge forces:
  - state = IDLE; gnt = 0; gnt_id = 0; gnt_vld = 0; timeout = 0; busy = 0;
  - hold_cnt = 0; last_id = 0; mask = 0.
  - rst mid-grant drops the grant on the next edge with no GAP cycle.
- States: IDLE, GRANT, GAP.
- IDLE:
  - Eligible vector is req & ~mask.
  - If en and eligible != 0: the winner is registered and the state moves to GRANT.
  - Latency: req sampled at edge n, gnt/gnt_id/gnt_vld valid after edge n, i.e. a 1-cycle registered response.
  - en low or eligible = 0: stay in IDLE with outputs at 0.
- Winner selection:
  - Fixed priority (rr_mode = 0): highest set index of eligible.
  - Round-robin (rr_mode = 1): search order is last_id-1, last_id-2, ... down to 0, then wrapping 7 ... last_id (modulo-8 descending). The first set bit in that order wins.
  - After reset, last_id = 0, so the first round-robin search starts at 7.
  - last_id is updated to the winner on every grant, in both modes.
- GRANT:
  - gnt = one-hot(gnt_id); hold_cnt increments each cycle, saturating at 255.
  - Release: req[gnt_id] sampled low leads to GAP; gnt clears after that edge.
  - Timeout: MAX_HOLD != 0, hold_cnt = MAX_HOLD-1, and req[gnt_id] still high leads to GAP. Effects:
    - timeout pulses for exactly the first GAP cycle;
    - mask[gnt_id] is set.
  - The grant lasts exactly MAX_HOLD cycles.
  - Release and timeout in the same cycle: treated as a normal release (no pulse, no mask).
  - en and rr_mode changes do not affect an active grant.
  - Requests from other indices never preempt the owner.
- GAP:
  - One idle cycle with gnt = 0 and busy = 1; hold_cnt is cleared.
  - Next state is IDLE, so back-to-back owners are separated by at least 1 cycle.
- Mask:
  - A set mask bit excludes that requester from the next arbitration only.
  - mask is cleared when any grant is issued.
  - A bit also clears when its req drops.
  - If the masked requester is the only one requesting, it is not granted until it deasserts req.
  - Starvation of a stuck requester is intentional and is flagged by timeout.
- Invariants (assertions required):
  - gnt is one-hot or zero.
  - gnt_vld == |gnt.
  - gnt == 0 whenever state != GRANT.
  - gnt_id is stable throughout a GRANT.
- req values of X are not handled; requesters drive 0/1 only.

Test Plan:
1. Fixed priority: rst, then req = 8'b0010_0110, en = 1, rr_mode = 0 → next cycle gnt = 8'b0010_0000, gnt_id = 5; drop req[5] → one GAP cycle, then gnt = 8'b0000_0100.
2. Round-robin: req = 8'hFF held high, rr_mode = 1, requesters drop req 2 cycles after grant and re-raise it → gnt_id sequence 7, 6, 5, 4, 3, 2, 1, 0, 7, each grant separated by one GAP cycle.
3. Timeout: MAX_HOLD = 4, req = 8'b1000_0001 held high, fixed mode → gnt_id = 7 for exactly 4 cycles, timeout pulses once, GAP, then gnt_id = 0 (7 masked); after the next arbitration, 7 wins again.
4. Enable gating: en = 0 with req = 8'h10 → gnt stays 0 indefinitely; raise en → gnt = 8'h10 after 1 cycle; drop en during GRANT → grant persists until req[4] drops.
5. Reset mid-grant: during GRANT with gnt_id = 3, assert rst for 1 cycle → all outputs 0 on the next edge; with rr_mode = 1 and req = 8'hFF after reset, the first grant is gnt_id = 7 (last_id reset to 0).
6. Simultaneous release and timeout: MAX_HOLD = 2, req[6] drops on the 2nd GRANT cycle → no timeout pulse, mask stays 0, normal GAP then IDLE.
